lcg_arbiter: RTL

Shares one 31-bit linear-congruential generator (LCG) multiply-add datapath among `N_REQ` display digits of the slot-machine game. Each digit keeps its own generator state, and the block arbitrates step requests round-robin through a 2-stage pipeline. It returns the new state and the decimal digit it encodes. It sits between the game FSM, which pulses one request per digit per reel tick, and the seven-segment decoders.

---
 rtl/lcg_pkg.sv | 19 +
 rtl/lcg_step.sv | 14 +
 rtl/lcg_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lcg_pkg.sv
// Shared constants, state type and seeding helper for the reel-digit LCG block.
package lcg_pkg;

  localparam logic [63:0] LCG_MUL  = 64'd1103515245;
  localparam logic [63:0] LCG_INC  = 64'd12345;
  localparam logic [30:0] LCG_MASK = 31'h7FFF_FFFF;
  localparam int unsigned DIG_HI   = 32'd20;
  localparam int unsigned DIG_LO   = 32'd16;

  typedef logic [30:0] lcg_state_t;

  // Seed of channel idx: base + step*idx, reduced to the 31-bit state space.
  function automatic lcg_state_t chan_seed(input logic [31:0] base,
                                           input int unsigned step,
                                           input int unsigned idx);
    return lcg_state_t'(base + (step * idx)) & LCG_MASK;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// One combinational LCG step: next = (x*LCG_MUL + LCG_INC) mod 2^31, plus the
// decimal digit shown on the reel.
module lcg_step
  import lcg_pkg::*;
(
  input  lcg_state_t state_i,
  output lcg_state_t next_o,
  output logic [4:0] digit_o
);

  assign next_o  = lcg_state_t'(({33'd0, state_i} * LCG_MUL + LCG_INC) & {33'd0, LCG_MASK});
  assign digit_o = 5'(next_o[DIG_HI:DIG_LO] % 5'd10);

endmodule

// File: rtl/lcg_arbiter.sv
// Per-digit LCG states sharing one step datapath: round-robin arbiter feeding a
// 2-stage pipeline (stage 1 = operand fetch, stage 2 = step + write-back).
module lcg_arbiter
  import lcg_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned SEED_STEP  = 7,
  parameter logic [31:0] RESET_SEED = 32'd0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_seed_load,
  input  logic [31:0]              i_seed,
  input  logic [N_REQ-1:0]         i_active,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_id,
  output lcg_state_t               o_value,
  output logic [4:0]               o_digit
);

  localparam int unsigned IDW = $clog2(N_REQ);
  typedef logic [IDW-1:0] id_t;

  function automatic id_t rr_idx(input id_t base, input int unsigned k);
    return id_t'((32'(base) + k) % N_REQ);
  endfunction

  lcg_state_t       state_q [N_REQ];
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] inflight_s, elig_s, gnt_s;
  logic [N_REQ-1:0] o_gnt_q;
  id_t              ptr_q, ptr_d, win_id_s, s1_id_q, o_id_q;
  logic             win_s, grant_s, s1_valid_q, o_valid_q;
  lcg_state_t       s1_state_q, o_value_q, next_s;
  logic [4:0]       digit_s, o_digit_q;

  // Arbitration: a channel sitting in stage 1 is skipped so it never fetches stale state.
  always_comb begin
    inflight_s = s1_valid_q ? (N_REQ'(1) << s1_id_q) : '0;
    elig_s     = pending_q & i_active & ~inflight_s;
    win_s      = 1'b0;
    win_id_s   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      id_t  cand;
      logic take;
      cand     = rr_idx(ptr_q, k);
      take     = !win_s && elig_s[cand];
      win_id_s = take ? cand : win_id_s;
      win_s    = win_s | take;
    end
    grant_s = win_s & ~i_seed_load;
    if (grant_s) begin
      gnt_s = N_REQ'(1) << win_id_s;
      ptr_d = rr_idx(win_id_s, 32'd1);
    end else begin
      gnt_s = '0;
      ptr_d = ptr_q;
    end
    if (i_seed_load) begin
      pending_d = '0;
    end else begin
      pending_d = ((pending_q & ~gnt_s) | (i_req & i_active)) & i_active;
    end
  end

  // Pending bits, pointer and both pipeline stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      o_gnt_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_state_q <= '0;
      o_valid_q  <= 1'b0;
      o_id_q     <= '0;
      o_value_q  <= '0;
      o_digit_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      o_gnt_q    <= gnt_s;
      s1_valid_q <= grant_s;
      s1_id_q    <= win_id_s;
      s1_state_q <= state_q[win_id_s];
      o_valid_q  <= s1_valid_q & ~i_seed_load;
      if (s1_valid_q && !i_seed_load) begin
        o_id_q    <= s1_id_q;
        o_value_q <= next_s;
        o_digit_q <= digit_s;
      end else begin
        o_id_q    <= o_id_q;
        o_value_q <= o_value_q;
        o_digit_q <= o_digit_q;
      end
    end
  end

  // State array: reseed wins over the stage-2 write-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        state_q[i] <= chan_seed(RESET_SEED, SEED_STEP, i);
      end
    end else if (i_seed_load) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        state_q[i] <= chan_seed(i_seed, SEED_STEP, i);
      end
    end else if (s1_valid_q) begin
      state_q[s1_id_q] <= next_s;
    end else begin
      state_q <= state_q;
    end
  end

  lcg_step u_step (
    .state_i (s1_state_q),
    .next_o  (next_s),
    .digit_o (digit_s)
  );

  assign o_gnt   = o_gnt_q;
  assign o_valid = o_valid_q;
  assign o_id    = o_id_q;
  assign o_value = o_value_q;
  assign o_digit = o_digit_q;

endmodule
